// File: rtl/pgr_uart_tx_arb_32bit.sv
// Two-requester round-robin UART transmitter: 8N1 frames timed by an oversampled clk_en.
// Optional even-parity bit compiled in with UART_TX_PARITY_EN.
module pgr_uart_tx_arb_32bit #(
    parameter int OVERSAMPLE = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       txd,
    output logic       busy
);

    localparam logic [3:0] TICK_MAX = 4'(OVERSAMPLE - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity_f(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t      state_r, state_nx_s;
    logic [3:0]  tick_cnt_r, tick_nx_s;
    logic [2:0]  bit_cnt_r, bit_nx_s;
    logic [7:0]  shift_r, shift_nx_s;
    logic        ptr_r, ptr_nx_s;
    logic        txd_r, txd_nx_s;
    logic        ack0_r, ack0_nx_s;
    logic        ack1_r, ack1_nx_s;
    logic        busy_r;
    logic        bit_end_s;
    logic        win1_s;
`ifdef UART_TX_PARITY_EN
    logic [7:0]  byte_r, byte_nx_s;
`endif

    assign bit_end_s = clk_en && (tick_cnt_r == TICK_MAX);

    // Next-state, arbitration, counters and next output values.
    always_comb begin
        state_nx_s = state_r;
        tick_nx_s  = tick_cnt_r;
        bit_nx_s   = bit_cnt_r;
        shift_nx_s = shift_r;
        ptr_nx_s   = ptr_r;
        ack0_nx_s  = 1'b0;
        ack1_nx_s  = 1'b0;
        win1_s     = 1'b0;
        txd_nx_s   = 1'b1;
`ifdef UART_TX_PARITY_EN
        byte_nx_s  = byte_r;
`endif

        if (clk_en && (state_r != ST_IDLE)) begin
            tick_nx_s = bit_end_s ? 4'd0 : (tick_cnt_r + 4'd1);
        end else begin
            tick_nx_s = tick_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (clk_en && (req0 || req1)) begin
                    // ptr_r == 1 means requester 1 has priority on a tie.
                    win1_s     = req1 && (!req0 || ptr_r);
                    ack0_nx_s  = !win1_s;
                    ack1_nx_s  = win1_s;
                    shift_nx_s = win1_s ? data1 : data0;
`ifdef UART_TX_PARITY_EN
                    byte_nx_s  = win1_s ? data1 : data0;
`endif
                    ptr_nx_s   = !win1_s;
                    tick_nx_s  = 4'd0;
                    bit_nx_s   = 3'd0;
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    bit_nx_s   = 3'd0;
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_nx_s = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_nx_s = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_nx_s = ST_PARITY;
`else
                        state_nx_s = ST_STOP;
`endif
                    end else begin
                        bit_nx_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                tick_nx_s  = 4'd0;
                bit_nx_s   = 3'd0;
            end
        endcase

        // txd is registered from the next state so it changes on the same edge as the state.
        case (state_nx_s)
            ST_IDLE:   txd_nx_s = 1'b1;
            ST_START:  txd_nx_s = 1'b0;
            ST_DATA:   txd_nx_s = shift_nx_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_nx_s = even_parity_f(byte_nx_s);
`endif
            ST_STOP:   txd_nx_s = 1'b1;
            default:   txd_nx_s = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            ptr_r      <= 1'b0;
            txd_r      <= 1'b1;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            byte_r     <= 8'd0;
`endif
        end else begin
            state_r    <= state_nx_s;
            tick_cnt_r <= tick_nx_s;
            bit_cnt_r  <= bit_nx_s;
            shift_r    <= shift_nx_s;
            ptr_r      <= ptr_nx_s;
            txd_r      <= txd_nx_s;
            ack0_r     <= ack0_nx_s;
            ack1_r     <= ack1_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
`ifdef UART_TX_PARITY_EN
            byte_r     <= byte_nx_s;
`endif
        end
    end

    assign txd  = txd_r;
    assign ack0 = ack0_r;
    assign ack1 = ack1_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_pgr_uart_tx_arb_32bit.sv
// Bench for pgr_uart_tx_arb_32bit: vector table plus hand sequences, frames decoded off txd
// and compared against a queue of expected bytes.
module tb_pgr_uart_tx_arb_32bit;

    localparam int BIT_CLK = 24;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLK = NBITS * BIT_CLK;
    localparam int STOP_S    = 12 + BIT_CLK * (NBITS - 1);

    typedef struct packed {
        logic [7:0] b;
        logic       p;
    } sb_t;

    typedef struct {
        logic       sel;
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    logic       clk, rst, clk_en, req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, txd, busy;

    int  checks = 0;
    int  errors = 0;
    int  ack0_n = 0;
    int  ack1_n = 0;
    sb_t exp_q[$];
    logic ce_seen, busy_prev;

    pgr_uart_tx_arb_32bit #(.OVERSAMPLE(6)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .txd(txd), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // clk_en every 4th clk, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        clk_en = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            clk_en = (div == 0);
        end
    end

    always @(posedge clk) begin
        ce_seen   <= clk_en;
        busy_prev <= busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every ack must come from IDLE on a clk_en cycle, one line at a time.
    initial begin
        forever begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                chk("ack_on_clk_en", {31'd0, ce_seen}, 32'd1);
                chk("ack_from_idle", {31'd0, busy_prev}, 32'd0);
                chk("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
                if (ack0 === 1'b1) ack0_n++;
                if (ack1 === 1'b1) ack1_n++;
            end
        end
    end

    // Frame decoder: samples mid-bit after each falling start edge; aborts if busy drops early.
    initial begin
        logic       active, prev, par;
        logic [7:0] rx;
        int         cnt;
        sb_t        e;
        active = 1'b0; prev = 1'b1; cnt = 0; rx = 8'd0; par = 1'b0;
        forever begin
            @(negedge clk);
            if (active) begin
                cnt++;
                if (busy !== 1'b1 && cnt < STOP_S) begin
                    active = 1'b0;
                end else if (cnt == 12) begin
                    chk("start_bit", {31'd0, txd}, 32'd0);
                end else if (cnt > 12 && cnt <= 12 + BIT_CLK * 8 && ((cnt - 12) % BIT_CLK) == 0) begin
                    rx[(cnt - 12) / BIT_CLK - 1] = txd;
`ifdef UART_TX_PARITY_EN
                end else if (cnt == 12 + BIT_CLK * 9) begin
                    par = txd;
`endif
                end else if (cnt == STOP_S) begin
                    chk("stop_bit", {31'd0, txd}, 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte", {24'd0, rx}, {24'd0, e.b});
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", {31'd0, par}, {31'd0, e.p});
`endif
                    end
                    active = 1'b0;
                end
            end else if (prev == 1'b1 && txd === 1'b0) begin
                active = 1'b1;
                cnt = 0;
            end
            prev = (txd === 1'b0) ? 1'b0 : 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic raise(input logic sel, input logic [7:0] d, input logic p, input logic push);
        if (sel) begin
            req1 = 1'b1; data1 = d;
        end else begin
            req0 = 1'b1; data0 = d;
        end
        if (push) exp_q.push_back({d, p});
    endtask

    // Wait for the ack, drop the request, then time busy; optionally raise req1 mid-frame.
    task automatic grant(input logic sel, output int waited,
                         input logic mid_en, input logic [7:0] mid_d, input logic mid_p);
        int n;
        logic got;
        n = 0;
        while (((sel ? ack1 : ack0) !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        got = (sel ? ack1 : ack0) === 1'b1;
        chk("ack_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("ack_other_low", {31'd0, sel ? ack0 : ack1}, 32'd0);
            chk("busy_at_ack", {31'd0, busy}, 32'd1);
            chk("txd_low_at_ack", {31'd0, txd}, 32'd0);
            if (sel) req1 = 1'b0; else req0 = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) chk("ack_one_cycle", {31'd0, sel ? ack1 : ack0}, 32'd0);
                if (mid_en && n == 50) raise(1'b1, mid_d, mid_p, 1'b1);
            end while (busy === 1'b1 && n < 2000);
            chk("busy_len", n, FRAME_CLK);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int w, bad, a0;
        vecs[0] = '{1'b0, 8'h55, 1'b0};
        vecs[1] = '{1'b1, 8'h07, 1'b1};
        vecs[2] = '{1'b0, 8'h03, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'h80, 1'b1};
        vecs[6] = '{1'b0, 8'h01, 1'b1};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = 8'd0; data1 = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        rst = 1'b0;

        // Idle with no requests.
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single 0x55 frame: one ack0 pulse.
        a0 = ack0_n;
        raise(1'b0, 8'h55, 1'b0, 1'b1);
        grant(1'b0, w, 1'b0, 8'd0, 1'b0);
        chk("grant_latency", {31'd0, w <= 4}, 32'd1);
        repeat (10) @(negedge clk);
        chk("ack0_pulses", ack0_n - a0, 1);

        // Table of single-requester frames.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            raise(vecs[i].sel, vecs[i].data, vecs[i].exp_par, 1'b1);
            grant(vecs[i].sel, w, 1'b0, 8'd0, 1'b0);
        end

        // Simultaneous requests from reset: req0 first, then req1, then req0 again.
        do_reset();
        raise(1'b0, 8'hA5, 1'b0, 1'b1);
        raise(1'b1, 8'h3C, 1'b0, 1'b1);
        grant(1'b0, w, 1'b0, 8'd0, 1'b0);
        grant(1'b1, w, 1'b0, 8'd0, 1'b0);
        chk("idle_gap_rr", w, 4);
        @(negedge clk);
        raise(1'b0, 8'h5A, 1'b0, 1'b1);
        raise(1'b1, 8'hC3, 1'b0, 1'b1);
        grant(1'b0, w, 1'b0, 8'd0, 1'b0);
        grant(1'b1, w, 1'b0, 8'd0, 1'b0);
        chk("idle_gap_rr2", w, 4);

        // req1 raised mid-frame waits for IDLE.
        @(negedge clk);
        raise(1'b0, 8'h69, 1'b0, 1'b1);
        grant(1'b0, w, 1'b1, 8'h96, 1'b0);
        grant(1'b1, w, 1'b0, 8'd0, 1'b0);
        chk("idle_gap_held", w, 4);

        // Reset in the middle of DATA abandons the frame.
        @(negedge clk);
        raise(1'b0, 8'hF0, 1'b0, 1'b0);
        w = 0;
        while (ack0 !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("abort_ack_seen", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        repeat (80) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_txd", {31'd0, txd}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (30) @(negedge clk);
        chk("postrst_quiet", {30'd0, busy, ~txd}, 32'd0);
        raise(1'b0, 8'hE1, 1'b0, 1'b1);
        grant(1'b0, w, 1'b0, 8'd0, 1'b0);

        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
